dsp_mulseq: RTL
===============

Name: dsp_mulseq

Overview:
- Multi-cycle WIDTH x WIDTH integer multiplier built on the Virtex-5 DSP48E multiply-accumulate style.
- Splits each operand into 17-bit limbs and issues one 17x17 partial product per cycle.
- Sequences the package DSP codes DSP_MUL1 (M+0), DSP_MUL2 (M+(P>>17)) and DSP_MUL3 (M+P) column by column.
- Sits behind the integer pipeline's multiply unit and generalises the fixed 32-bit MUL1..MUL4 sequence to any width, with valid/ready handshakes and optional signed mode.

Parameters:
- WIDTH, 32, operand width in bits; legal range 17..64.
- N (localparam), ceil(WIDTH/17), limbs per operand.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, block can accept an operation.
- op_a, input, WIDTH, multiplicand.
- op_b, input, WIDTH, multiplier.
- sgn, input, 1, signed operation; ignored unless DSP_MULSEQ_SIGNED_EN is defined.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- result, output, 2*WIDTH, product.
- busy, output, 1, operation in flight (state != IDLE).
- dsp_opmode, output, 7, current step's opmode; 0 when no product is issued.
- dsp_alumode, output, 4, current step's alumode; always 0.

Behaviour:
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, dsp_opmode=0, dsp_alumode=0. P accumulator and step counters are cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch the operands and go to MUL.
  - MUL: issues N*N products, one per cycle, then goes to FIN.
  - FIN: one cycle, assembles result, then goes to DONE.
  - DONE: out_valid=1 until out_ready, then goes to IDLE.
- in_ready is 0 in MUL, FIN and DONE. There is no accept in the same cycle as result hand-off.
- Product ordering is by column k = i+j, k = 0..2N-2; within a column, i ascends. a_i and b_j are zero-extended 17-bit limbs.
- Opmode per product:
  - First product of column 0: DSP_MUL1.
  - First product of any column k>0: DSP_MUL2.
  - Other products: DSP_MUL3.
- P is a 48-bit register; P <= M + {0, P>>17, or P} per the opmode.
- At each column change, the low 17 bits of P (before the shift) are stored as result limb k-1.
- FIN: result = {P, limbs 2N-3..0} truncated to 2*WIDTH bits.
- Latency: out_valid rises N*N+1 cycles after the accept edge. For WIDTH=32 that is 5 cycles.
- dsp_opmode is valid in the same cycle P is updated. It is 0 in IDLE, FIN and DONE.
- result is stable for the whole time out_valid=1.
- rst during any state aborts the operation: out_valid drops the next cycle and no partial result is presented.
- Zero operands run the full sequence; there is no early termination.

Optional Feature:
- Macro: DSP_MULSEQ_SIGNED_EN.
- Defined:
  - When sgn=1, operands are converted to their magnitudes at accept (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)).
  - The negate flag is sign(a) xor sign(b).
  - FIN applies a two's-complement negate to the 2*WIDTH result when the flag is set.
  - Latency is unchanged.
- Absent: sgn is ignored and all operations are unsigned; no negate logic is generated.

Decomposition:
- libtech gains:
  - dsp_mulseq_state_type enum {IDLE, MUL, FIN, DONE}.
  - Constant DSP_LIMB = 17.
  - Function dsp_limbs(width) returning ceil(width/17).
- Opmodes come from the existing DSP_MUL1/MUL2/MUL3 constants.
- One sub-module, dsp48_mac_model: behavioural 17x17 M, 48-bit P, opmode-selected Z-mux. It can later be swapped for a DSP48E primitive.

Test Plan:
- WIDTH=32, 0xFFFFFFFF x 0xFFFFFFFF unsigned -> result 0xFFFFFFFE00000001.
  - out_valid exactly 5 cycles after accept.
  - dsp_opmode sequence 0000101, 1100101, 0100101, 1100101.
- 0x00010000 x 0x00010000 -> 0x0000000100000000. out_ready held low 3 cycles -> result stable and in_ready=0 throughout.
- SIGNED_EN, sgn=1:
  - 0xFFFFFFFE x 0x00000003 -> 0xFFFFFFFFFFFFFFFA.
  - 0x80000000 x 0x80000000 -> 0x4000000000000000.
- rst asserted in cycle 2 of MUL -> next cycle in_ready=1, out_valid=0, result=0. A following 2 x 3 returns 6.
- WIDTH=64 (N=4), 0xFFFFFFFFFFFFFFFF squared -> 0xFFFFFFFFFFFFFFFE0000000000000001. out_valid 17 cycles after accept.
- Back-to-back: in_valid held high over two operations -> second is accepted only in the cycle after the out_valid/out_ready handshake.

Source files
------------

// File: rtl/dsp_mulseq_pkg.sv
// Shared definitions for the multi-cycle DSP48E-style multiplier.
//   dsp_mulseq_state_type : sequencer states IDLE/MUL/FIN/DONE
//   DSP_LIMB              : limb width of one DSP multiplier input
//   DSP_MUL1/2/3          : DSP48E opmodes M+0, M+(P>>17), M+P
//   dsp_limbs(width)      : number of 17-bit limbs needed for a width
package dsp_mulseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } dsp_mulseq_state_type;

  localparam int DSP_LIMB = 17;

  // opmode = {Z[2:0], Y[1:0], X[1:0]}; X/Y select M, Z selects the adder's third input
  localparam logic [6:0] DSP_MUL1 = 7'b0000101;  // P = M
  localparam logic [6:0] DSP_MUL2 = 7'b1100101;  // P = M + (P >> 17)
  localparam logic [6:0] DSP_MUL3 = 7'b0100101;  // P = M + P

  function automatic int dsp_limbs(input int width);
    return (width + DSP_LIMB - 1) / DSP_LIMB;
  endfunction

endpackage

// File: rtl/dsp48_mac_model.sv
// Behavioural stand-in for one DSP48E slice used as a 17x17 multiply-accumulate.
// Can be replaced by the vendor primitive without touching the sequencer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears P)
//   ce         : P update enable
//   a, b       : 17-bit unsigned multiplier inputs
//   opmode     : DSP48E opmode; only the Z field [6:4] changes behaviour here
//   p          : 48-bit accumulator register
module dsp48_mac_model
  import dsp_mulseq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [16:0] a,
  input  logic [16:0] b,
  input  logic [6:0]  opmode,
  output logic [47:0] p
);

  logic [33:0] m;
  logic [47:0] z;
  logic [47:0] p_n;
  logic        unused_xy;

  // X/Y always route M in this multiplier, so those fields are not decoded
  assign unused_xy = ^opmode[3:0];

  assign m = {17'd0, a} * {17'd0, b};

  always_comb begin
    z = '0;
    case (opmode[6:4])
      DSP_MUL3[6:4]: z = p;
      DSP_MUL2[6:4]: z = {{DSP_LIMB{1'b0}}, p[47:DSP_LIMB]};
      default:       z = '0;
    endcase
  end

  assign p_n = {14'd0, m} + z;

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (ce) begin
      p <= p_n;
    end
  end

endmodule

// File: rtl/dsp_mulseq.sv
// Multi-cycle WIDTH x WIDTH multiplier that walks the partial products of
// 17-bit limbs column by column through a single DSP48E-style MAC.
// Optional signed mode is built when DSP_MULSEQ_SIGNED_EN is defined;
// otherwise sgn is ignored and all operations are unsigned.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (op_a, op_b, sgn)
//   out_valid / out_ready : result handshake (result, 2*WIDTH bits)
//   busy                  : an operation is in flight
//   dsp_opmode            : opmode of the product issued this cycle, 0 otherwise
//   dsp_alumode           : always 0 (add)
module dsp_mulseq
  import dsp_mulseq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic [6:0]         dsp_opmode,
  output logic [3:0]         dsp_alumode
);

  localparam int N     = dsp_limbs(WIDTH);
  localparam int EXT_W = DSP_LIMB * N;
  localparam int CW    = $clog2(2 * N) + 1;
  localparam int ASM_W = DSP_LIMB * (2 * N - 1) + 48;
  localparam logic [CW-1:0] NM1      = CW'(N - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(2 * N - 2);

  dsp_mulseq_state_type state, state_n;

  logic [EXT_W-1:0]   a_q, b_q;
  logic [CW-1:0]      col_q, idx_q, col_n, idx_n;
  logic [CW-1:0]      col_inc, jdx, imin, imax, imin_next;
  logic               first_in_col, last_in_col;
  logic [16:0]        a_limb, b_limb;
  logic [6:0]         opmode;
  logic               mac_ce, limb_we;
  logic [47:0]        p;
  logic [16:0]        limb_q [2*N-1];
  logic [ASM_W-1:0]   asm_v;
  logic [2*WIDTH-1:0] asm_lo;
  logic [2*WIDTH-1:0] result_q;
  logic               unused_asm;

`ifdef DSP_MULSEQ_SIGNED_EN
  logic neg_q;

  // -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
`endif

  // ---- column/limb index bookkeeping ----
  assign col_inc   = col_q + 1'b1;
  assign jdx       = col_q - idx_q;
  assign imin      = (col_q > NM1) ? (col_q - NM1) : '0;
  assign imax      = (col_q < NM1) ? col_q : NM1;
  assign imin_next = (col_inc > NM1) ? (col_inc - NM1) : '0;
  assign first_in_col = (idx_q == imin);
  assign last_in_col  = (idx_q == imax);

  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == CW'(i)) a_limb = a_q[i*DSP_LIMB +: DSP_LIMB];
      if (jdx == CW'(i))   b_limb = b_q[i*DSP_LIMB +: DSP_LIMB];
    end
  end

  // ---- sequencer ----
  always_comb begin
    state_n = state;
    col_n   = col_q;
    idx_n   = idx_q;
    opmode  = '0;
    mac_ce  = 1'b0;
    limb_we = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = MUL;
          col_n   = '0;
          idx_n   = '0;
        end
      end
      MUL: begin
        mac_ce = 1'b1;
        if (first_in_col && col_q == '0) opmode = DSP_MUL1;
        else if (first_in_col)           opmode = DSP_MUL2;
        else                             opmode = DSP_MUL3;
        // entering a new column: P still holds the finished previous column
        limb_we = first_in_col && (col_q != '0);
        if (last_in_col) begin
          if (col_q == LAST_COL) begin
            state_n = FIN;
          end else begin
            col_n = col_inc;
            idx_n = imin_next;
          end
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      FIN:  state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col_q <= '0;
      idx_q <= '0;
    end else begin
      state <= state_n;
      col_q <= col_n;
      idx_q <= idx_n;
    end
  end

  // ---- operand capture at accept ----
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
`ifdef DSP_MULSEQ_SIGNED_EN
      a_q <= EXT_W'(magnitude(op_a, sgn));
      b_q <= EXT_W'(magnitude(op_b, sgn));
`else
      a_q <= EXT_W'(op_a);
      b_q <= EXT_W'(op_b);
`endif
    end
  end

`ifdef DSP_MULSEQ_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg_q <= sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end
  end
`endif

  // ---- MAC stage ----
  dsp48_mac_model u_mac (
    .clk    (clk),
    .rst    (rst),
    .ce     (mac_ce),
    .a      (a_limb),
    .b      (b_limb),
    .opmode (opmode),
    .p      (p)
  );

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2*N-1; k++) begin
      if (limb_we && col_q == CW'(k + 1)) limb_q[k] <= p[16:0];
    end
  end

  // ---- result assembly: completed column limbs below, final P on top ----
  always_comb begin
    asm_v = '0;
    for (int k = 0; k < 2*N-2; k++) asm_v[k*DSP_LIMB +: DSP_LIMB] = limb_q[k];
    asm_v[(2*N-2)*DSP_LIMB +: 48] = p;
  end

  assign asm_lo     = asm_v[2*WIDTH-1:0];
  assign unused_asm = ^asm_v[ASM_W-1:2*WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (state == FIN) begin
`ifdef DSP_MULSEQ_SIGNED_EN
      result_q <= neg_q ? negate(asm_lo) : asm_lo;
`else
      result_q <= asm_lo;
`endif
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign result      = result_q;
  assign dsp_opmode  = opmode;
  assign dsp_alumode = 4'd0;

endmodule
